multi_clock_divider: RTL and testbench

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

---
 rtl/clock_div_pkg.sv | 9 +
 rtl/clock_div_channel.sv | 49 ++++
 rtl/multi_clock_divider.sv | 38 +++
 tb/tb_multi_clock_divider.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared defaults and channel-index width helper for the clock divider
package clock_div_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int DIV_W_DEF = 8;
  localparam int RESET_DIV_DEF = 1;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clock_div_channel.sv
// clock_div_channel: one divider channel with a pending divisor applied at period boundaries
module clock_div_channel #(
  parameter int DIV_W = 8,
  parameter int RESET_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync,
  output logic             pend,
  output logic             div_clk,
  output logic             div_tick
);
  logic [DIV_W-1:0] d, p, cnt;
  logic wrap, apply;
  assign wrap = d != '0 && cnt == d - 1'b1;
  // A pending divisor lands on the falling toggle, or right away when stopped
  assign apply = pend && (d == '0 || (wrap && div_clk));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d <= DIV_W'(RESET_DIV);
      p <= '0;
      pend <= 1'b0;
      cnt <= '0;
      div_clk <= 1'b0;
      div_tick <= 1'b0;
    end else if (sync) begin
      cnt <= '0;
      div_clk <= 1'b0;
      div_tick <= 1'b0;
      pend <= 1'b0;
      if (wr) begin
        d <= wr_div;
        p <= wr_div;
      end else if (pend) d <= p;
    end else begin
      div_tick <= wrap && !div_clk;
      div_clk <= d != '0 && (div_clk ^ wrap);
      cnt <= (d == '0 || wrap) ? '0 : cnt + 1'b1;
      if (apply) begin
        d <= p;
        pend <= 1'b0;
      end else if (wr) begin
        p <= wr_div;
        pend <= 1'b1;
      end
    end
endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent clock dividers with write decode and ready mux
module multi_clock_divider
  import clock_div_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int RESET_DIV = RESET_DIV_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic                      sync,
  output logic [NUM_CH-1:0]         div_clk,
  output logic [NUM_CH-1:0]         div_tick
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam int NP = 1 << CH_W;
  logic [NUM_CH-1:0] pend;
  logic [NP-1:0] pend_x;
  // Padded so out-of-range channel indices read a defined bit
  assign pend_x = NP'(pend);
  assign cfg_ready = 32'(cfg_ch) < NUM_CH && !pend_x[cfg_ch];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_div_channel #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) u_ch (
      .clk(clk),
      .reset(reset),
      .wr(cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
      .wr_div(cfg_div),
      .sync(sync),
      .pend(pend[i]),
      .div_clk(div_clk[i]),
      .div_tick(div_tick[i])
    );
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: random and directed stimulus checked against a phase-age reference model
module tb_multi_clock_divider;
  localparam int NUM_CH = 3;
  localparam int DIV_W = 8;
  localparam int RESET_DIV = 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic sync = 1'b0;
  logic [NUM_CH-1:0] div_clk, div_tick;
  int n_cmp = 0;
  int n_bad = 0;
  int md[NUM_CH], mp[NUM_CH], mf[NUM_CH], mage[NUM_CH];
  multi_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .sync(sync),
    .div_clk(div_clk),
    .div_tick(div_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      md[i] = RESET_DIV;
      mp[i] = 0;
      mf[i] = 0;
      mage[i] = 0;
    end
  endtask
  // Expected level: low for the first D cycles of each 2D-cycle period, then high
  task automatic check_outputs(input string tag);
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("%s clk%0d", tag, i), int'(div_clk[i]), (md[i] != 0 && mage[i] >= md[i]) ? 1 : 0);
      chk($sformatf("%s tick%0d", tag, i), int'(div_tick[i]), (md[i] != 0 && mage[i] == md[i]) ? 1 : 0);
    end
  endtask
  task automatic step(input logic v, input logic [1:0] ch, input int dv, input logic s);
    logic rdy;
    logic acc;
    @(negedge clk);
    cfg_valid = v;
    cfg_ch = ch;
    cfg_div = DIV_W'(dv);
    sync = s;
    #1;
    rdy = (int'(ch) < NUM_CH) ? (mf[int'(ch) % NUM_CH] == 0) : 1'b0;
    chk("ready", int'(cfg_ready), int'(rdy));
    acc = v && rdy;
    @(posedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      if (s) begin
        mage[i] = 0;
        if (acc && int'(ch) == i) begin
          md[i] = dv;
          mp[i] = dv;
        end else if (mf[i] != 0) md[i] = mp[i];
        mf[i] = 0;
      end else begin
        if (md[i] == 0) begin
          mage[i] = 0;
          if (mf[i] != 0) begin
            md[i] = mp[i];
            mf[i] = 0;
          end
        end else begin
          mage[i] = (mage[i] + 1) % (2 * md[i]);
          if (mage[i] == 0 && mf[i] != 0) begin
            md[i] = mp[i];
            mf[i] = 0;
          end
        end
        if (acc && int'(ch) == i) begin
          mp[i] = dv;
          mf[i] = 1;
        end
      end
    end
    #1;
    check_outputs("step");
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 0, 1'b0);
  endtask
  // Called just after a step's check, between edges, so no edge is missed by the model
  task automatic async_reset();
    #1 reset = 1'b0;
    #1;
    chk("arst clk", int'(div_clk), 0);
    chk("arst tick", int'(div_tick), 0);
    model_reset();
    #1 reset = 1'b1;
  endtask
  initial begin
    model_reset();
    #1;
    chk("rst clk", int'(div_clk), 0);
    chk("rst tick", int'(div_tick), 0);
    chk("rst ready", int'(cfg_ready), 1);
    #6 reset = 1'b1;
    idle(4);
    step(1'b1, 2'd1, 3, 1'b0);
    idle(14);
    step(1'b1, 2'd2, 4, 1'b0);
    step(1'b1, 2'd2, 7, 1'b0);
    step(1'b0, 2'd0, 0, 1'b0);
    idle(10);
    step(1'b1, 2'd0, 0, 1'b0);
    idle(4);
    step(1'b1, 2'd0, 2, 1'b0);
    idle(6);
    step(1'b1, 2'd1, 3, 1'b0);
    idle(8);
    step(1'b1, 2'd2, 5, 1'b0);
    idle(12);
    step(1'b0, 2'd0, 0, 1'b1);
    idle(12);
    step(1'b1, 2'd3, 5, 1'b0);
    step(1'b1, 2'd1, 4, 1'b1);
    idle(10);
    step(1'b1, 2'd2, 9, 1'b0);
    idle(2);
    async_reset();
    step(1'b0, 2'd2, 0, 1'b0);
    idle(4);
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7)),
           $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
